// File: rtl/grid_step_sequencer.sv
// -----------------------------------------------------------------------------
// grid_step_sequencer
//
// Central timestep synchroniser for the heat-grid column engines. It holds the
// columns in reset during initialisation and then gathers one completion pulse
// from every active column. When all active columns are done it counts the
// timestep and, if running, launches the next one with a single global start
// pulse.
//
// Optional feature macro: GRID_STEP_WATCHDOG_EN
//   Adds parameter WDOG_CYCLES and output stall. The watchdog aborts to DONE
//   when COLLECT sees no done pulse for WDOG_CYCLES cycles.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   init_req    one-cycle pulse: (re)initialise the grid and start sequencing
//   run         level: 1 = advance timesteps, 0 = pause at next step boundary
//   num_active  active column count (0 -> 1, > NUM_COLS -> NUM_COLS), latched at init
//   iter_limit  timesteps to run, 0 = unlimited, latched at init
//   col_done    per-column one-cycle timestep-finished pulses
//   col_reset   reset to all column engines (high in INIT)
//   col_start   one-cycle global start pulse
//   iter_count  completed timesteps since the last init
//   busy        high in INIT, COLLECT, ISSUE and HOLD
//   halted      high in DONE
//   overrun     sticky: a done pulse arrived while it could not be used
//   stall       (watchdog build only) sticky: COLLECT timed out
// -----------------------------------------------------------------------------
module grid_step_sequencer #(
   parameter int NUM_COLS    = 32,
   parameter int COL_W       = 8,
   parameter int ITER_W      = 32,
   parameter int INIT_CYCLES = 4
`ifdef GRID_STEP_WATCHDOG_EN
   ,parameter int WDOG_CYCLES = 65535
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init_req,
   input  logic                run,
   input  logic [COL_W-1:0]    num_active,
   input  logic [ITER_W-1:0]   iter_limit,
   input  logic [NUM_COLS-1:0] col_done,
   output logic                col_reset,
   output logic                col_start,
   output logic [ITER_W-1:0]   iter_count,
   output logic                busy,
   output logic                halted,
   output logic                overrun
`ifdef GRID_STEP_WATCHDOG_EN
   ,output logic               stall
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_COLLECT = 3'd2,
      S_HOLD    = 3'd3,
      S_ISSUE   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0]   INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [INIT_W-1:0]   INIT_ONE  = INIT_W'(1);
   localparam logic [ITER_W-1:0]   ITER_ZERO = {ITER_W{1'b0}};
   localparam logic [ITER_W-1:0]   ITER_ONE  = ITER_W'(1);
   localparam logic [NUM_COLS-1:0] COLS_ZERO = {NUM_COLS{1'b0}};

   // Map the requested column count onto 1..NUM_COLS.
   function automatic int clamp_active(input logic [COL_W-1:0] n);
      int v;
      v = int'(n);
      if (v == 32'sd0) begin
         return 32'sd1;
      end else if (v > NUM_COLS) begin
         return NUM_COLS;
      end else begin
         return v;
      end
   endfunction

   // Thermometer mask: bit i set iff i < active.
   function automatic logic [NUM_COLS-1:0] build_mask(input int active);
      logic [NUM_COLS-1:0] m;
      m = COLS_ZERO;
      for (int i = 32'sd0; i < NUM_COLS; i++) begin
         if (i < active) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   state_t              state_r;
   state_t              state_next_s;
   logic [INIT_W-1:0]   init_cnt_r;
   logic [NUM_COLS-1:0] seen_r;
   logic [NUM_COLS-1:0] mask_r;
   logic [ITER_W-1:0]   limit_r;
   logic [ITER_W-1:0]   iter_count_r;
   logic                overrun_r;

   logic                col_reset_r;
   logic                col_start_r;
   logic                busy_r;
   logic                halted_r;
   logic                col_reset_next_s;
   logic                col_start_next_s;
   logic                busy_next_s;
   logic                halted_next_s;

   logic [NUM_COLS-1:0] seen_merge_s;
   logic                complete_s;
   logic [ITER_W-1:0]   iter_inc_s;
   logic                last_step_s;
   logic                wdog_expire_s;

   // The current cycle's pulses count toward completion, so a step can finish
   // on the same cycle its last column reports.
   assign seen_merge_s = (seen_r | col_done) & mask_r;
   assign complete_s   = (state_r == S_COLLECT) && (seen_merge_s == mask_r);
   assign iter_inc_s   = iter_count_r + ITER_ONE;
   assign last_step_s  = (limit_r != ITER_ZERO) && (iter_inc_s == limit_r);

`ifdef GRID_STEP_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
   localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

   logic [WDOG_W-1:0] wdog_cnt_r;
   logic              stall_r;

   // Expires on the WDOG_CYCLES-th consecutive quiet COLLECT cycle; a step
   // completing on that same cycle takes priority.
   assign wdog_expire_s = (state_r == S_COLLECT) && !complete_s &&
                          (col_done == COLS_ZERO) && (wdog_cnt_r == WDOG_LAST);

   // Watchdog counter and sticky stall flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_cnt_r <= {WDOG_W{1'b0}};
         stall_r    <= 1'b0;
      end else if (init_req) begin
         wdog_cnt_r <= {WDOG_W{1'b0}};
         stall_r    <= 1'b0;
      end else begin
         if ((state_r != S_COLLECT) || (col_done != COLS_ZERO)) begin
            wdog_cnt_r <= {WDOG_W{1'b0}};
         end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_ONE;
         end
         if (wdog_expire_s) begin
            stall_r <= 1'b1;
         end else begin
            stall_r <= stall_r;
         end
      end
   end

   assign stall = stall_r;
`else
   assign wdog_expire_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; init_req overrides every state.
   always_comb begin
      state_next_s = state_r;
      if (init_req) begin
         state_next_s = S_INIT;
      end else begin
         case (state_r)
            S_IDLE: begin
               state_next_s = S_IDLE;
            end
            S_INIT: begin
               if (init_cnt_r == INIT_LAST) begin
                  state_next_s = S_COLLECT;
               end else begin
                  state_next_s = S_INIT;
               end
            end
            S_COLLECT: begin
               if (complete_s) begin
                  if (last_step_s) begin
                     state_next_s = S_DONE;
                  end else if (run) begin
                     state_next_s = S_ISSUE;
                  end else begin
                     state_next_s = S_HOLD;
                  end
               end else if (wdog_expire_s) begin
                  state_next_s = S_DONE;
               end else begin
                  state_next_s = S_COLLECT;
               end
            end
            S_HOLD: begin
               if (run) begin
                  state_next_s = S_ISSUE;
               end else begin
                  state_next_s = S_HOLD;
               end
            end
            S_ISSUE: begin
               state_next_s = S_COLLECT;
            end
            S_DONE: begin
               state_next_s = S_DONE;
            end
            default: begin
               state_next_s = S_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so the registered outputs line up with
   // the state they describe.
   always_comb begin
      col_reset_next_s = 1'b0;
      col_start_next_s = 1'b0;
      busy_next_s      = 1'b0;
      halted_next_s    = 1'b0;
      case (state_next_s)
         S_INIT: begin
            col_reset_next_s = 1'b1;
            busy_next_s      = 1'b1;
         end
         S_COLLECT, S_HOLD: begin
            busy_next_s      = 1'b1;
         end
         S_ISSUE: begin
            col_start_next_s = 1'b1;
            busy_next_s      = 1'b1;
         end
         S_DONE: begin
            halted_next_s    = 1'b1;
         end
         default: begin
            col_reset_next_s = 1'b0;
            col_start_next_s = 1'b0;
            busy_next_s      = 1'b0;
            halted_next_s    = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_reset_r <= 1'b0;
         col_start_r <= 1'b0;
         busy_r      <= 1'b0;
         halted_r    <= 1'b0;
      end else begin
         col_reset_r <= col_reset_next_s;
         col_start_r <= col_start_next_s;
         busy_r      <= busy_next_s;
         halted_r    <= halted_next_s;
      end
   end

   // Configuration latch, init timer, seen vector, step counter and overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_r       <= COLS_ZERO;
         limit_r      <= ITER_ZERO;
         init_cnt_r   <= {INIT_W{1'b0}};
         seen_r       <= COLS_ZERO;
         iter_count_r <= ITER_ZERO;
         overrun_r    <= 1'b0;
      end else if (init_req) begin
         mask_r       <= build_mask(clamp_active(num_active));
         limit_r      <= iter_limit;
         init_cnt_r   <= {INIT_W{1'b0}};
         seen_r       <= COLS_ZERO;
         iter_count_r <= ITER_ZERO;
         overrun_r    <= 1'b0;
      end else begin
         case (state_r)
            S_INIT: begin
               init_cnt_r <= init_cnt_r + INIT_ONE;
            end
            S_COLLECT: begin
               if (complete_s) begin
                  iter_count_r <= iter_inc_s;
                  seen_r       <= COLS_ZERO;
               end else begin
                  seen_r       <= seen_merge_s;
               end
            end
            // Pulses outside COLLECT cannot belong to the current step.
            S_HOLD, S_ISSUE, S_DONE: begin
               if (col_done != COLS_ZERO) begin
                  overrun_r <= 1'b1;
               end else begin
                  overrun_r <= overrun_r;
               end
            end
            default: begin
               seen_r <= seen_r;
            end
         endcase
      end
   end

   assign col_reset  = col_reset_r;
   assign col_start  = col_start_r;
   assign busy       = busy_r;
   assign halted     = halted_r;
   assign iter_count = iter_count_r;
   assign overrun    = overrun_r;

endmodule
